rr_arb_real: RTL and testbench
==============================

# rr_arb_real

Four-requester round-robin arbiter sharing a single registered fixed-point real output between four producers. Each cycle it selects one requesting input, realigns the value to the output real format the same way the library's select and assign blocks do, and holds it in a one-entry output register with a valid/ready handshake. It sits in front of a shared downstream consumer, such as a single filter, accumulator or DAC model fed by several sources.

## Interface
- Real-format parameters for `in0`, `in1`, `in2` and `in3`, one set per input. Each set is declared with the library's real-declaration macro and gives range, width and exponent.
- Real-format parameter set for `out`, declared with the same macro.
- `clk`  input  1  clock; all state is updated on its rising edge.
- `rst`  input  1  asynchronous, active-high reset.
- `req`  input  4  `req[i]` means `in_i` holds a valid sample.
- `in0`..`in3`  input  in_i_width each  signed fixed-point samples, each in its own format.
- `gnt`  output  4  one-hot. `gnt[i]` is high in the cycle `in_i` is accepted. It is combinational.
- `out`  output  out_width  registered, selected sample in the `out` format.
- `out_valid`  output  1  `out` holds an unconsumed sample.
- `out_ready`  input  1  the downstream consumer takes `out` this cycle.

## Operation
- **Alignment:** each input is converted to the `out` format.
  - Shift by `in_i_exponent - out_exponent`.
  - A left shift fills with zeros.
  - A right shift is arithmetic and floors toward -inf.
  - There is no saturation. The `out` format must cover every input's range.
- **Accept condition:**
  - `accept = |req & (!out_valid | out_ready)`.
  - `gnt = accept ? winner : 4'b0000`.
- **Winner:** the first set bit of `req`, searching circularly from `last+1` (mod 4). `last` is a 2-bit pointer.
- **On a clock edge with accept:**
  - `out <= aligned in_winner`.
  - `out_valid <= 1`.
  - `last <= index(winner)`.
- **On a clock edge without accept:**
  - If `out_valid & out_ready`, then `out_valid <= 0`. `out` keeps its value.
  - Otherwise all state holds.
- `last` changes only when a request is granted. Requests are never lost: a requester keeps `req` high until it sees `gnt`.
- **Fairness:** with all four requesting continuously and `out_ready=1`, grants cycle 0,1,2,3,0… Any single requester waits at most 3 other grants.
- **Reset values:** `out=0`, `out_valid=0`, `last=3`. After reset, requester 0 has top priority. `gnt` is 0 while `rst` is high.

## Timing
- Latency from `gnt[i]` to that sample on `out` with `out_valid=1` is 1 cycle.
- Throughput is 1 sample per cycle when `out_ready` is held high. The register refills in the same edge that it drains.
- **Backpressure:** while `out_valid=1` and `out_ready=0`:
  - `gnt=0`.
  - `out`, `out_valid` and `last` are stable.
  - `req` is ignored.
- **Simultaneous drain and accept:** `out_valid` stays 1 and `out` takes the new sample.
- **Drain with no request:** `out_valid` falls on the next edge.
- **Reset mid-operation:** asserting `rst` immediately clears `out`, `out_valid` and `last=3`, asynchronously. Any pending sample is discarded. The first edge after `rst` falls can accept.
- `req` changes within a cycle only affect `gnt` combinationally. Arbitration has no extra cycle of latency.

## Test plan
Bench formats: `in0`..`in3` use width 16 and exponent -8; `out` uses width 16 and exponent -6.

- **Reset:** hold `rst=1` with `req=4'b1111`.
  - Expect `out=0`, `out_valid=0`, `gnt=0`.
  - Release reset with `req=4'b1111`. Expect `gnt=4'b0001` in the first cycle.
- **Alignment:** `in2=384` (1.5), `in2=-385`, with only `req[2]` set.
  - For 384, expect `out=96` one cycle after `gnt[2]`.
  - For -385, expect `out=-97` (floor).
- **Rotation:** `req=4'b1111` and `out_ready=1` for 8 cycles.
  - Expect `gnt` sequence 0001, 0010, 0100, 1000, repeated twice.
  - Expect `out` to follow each granted input one cycle later.
- **Backpressure:** `out_valid=1`, `out_ready=0` for 5 cycles with `req=4'b0110`.
  - Expect `gnt=0` and `out` unchanged.
  - Raise `out_ready` for one cycle. Expect one grant, in the correct order after `last`, and `out` replaced on that edge.
- **Drain:** after a single grant, drop all `req` and hold `out_ready=1`.
  - Expect `out_valid` 1 for one cycle, then 0.
  - Expect `out` to keep the last value.
- **Reset mid-operation:** assert `rst` asynchronously, between edges, while `out_valid=1` and `last=1`.
  - Expect `out=0` and `out_valid=0` before the next edge.
  - After release with `req=4'b1010`, expect `gnt=4'b0010`.

Source files
------------

// File: rtl/rr_arb_real.sv
// Four-way round-robin arbiter feeding one registered fixed-point real output.
// Each input is realigned to the out format; a one-entry register with valid/ready holds the result.
module rr_arb_real #(
    parameter int in0_width    = 16,
    parameter int in0_exponent = -8,
    parameter int in1_width    = 16,
    parameter int in1_exponent = -8,
    parameter int in2_width    = 16,
    parameter int in2_exponent = -8,
    parameter int in3_width    = 16,
    parameter int in3_exponent = -8,
    parameter int out_width    = 16,
    parameter int out_exponent = -6
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [3:0]                  req,
    input  logic signed [in0_width-1:0] in0,
    input  logic signed [in1_width-1:0] in1,
    input  logic signed [in2_width-1:0] in2,
    input  logic signed [in3_width-1:0] in3,
    output logic [3:0]                  gnt,
    output logic signed [out_width-1:0] out,
    output logic                        out_valid,
    input  logic                        out_ready
);

    // Positive shift moves left (zero fill); negative is an arithmetic right shift, flooring.
    function automatic logic signed [63:0] align(input logic signed [63:0] v, input int sh);
        if (sh >= 0)
            align = v <<< sh;
        else
            align = v >>> (-sh);
    endfunction

    logic signed [out_width-1:0] aligned [4];
    logic [1:0] last;
    logic [1:0] winner;
    logic [1:0] idx;
    logic       found;
    logic       accept;

    assign aligned[0] = out_width'(align(64'(in0), in0_exponent - out_exponent));
    assign aligned[1] = out_width'(align(64'(in1), in1_exponent - out_exponent));
    assign aligned[2] = out_width'(align(64'(in2), in2_exponent - out_exponent));
    assign aligned[3] = out_width'(align(64'(in3), in3_exponent - out_exponent));

    // Circular search starting just after the last granted requester.
    always_comb begin
        winner = '0;
        idx    = '0;
        found  = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            idx = last + 2'(k);
            if (!found && req[idx]) begin
                found  = 1'b1;
                winner = idx;
            end
        end
    end

    assign accept = !rst && found && (!out_valid || out_ready);
    assign gnt    = accept ? (4'b0001 << winner) : 4'b0000;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out       <= '0;
            out_valid <= 1'b0;
            last      <= 2'd3;
        end else if (accept) begin
            out       <= aligned[winner];
            out_valid <= 1'b1;
            last      <= winner;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_rr_arb_real.sv
// Directed bench for rr_arb_real: table of per-cycle vectors plus hand-written reset sequences.
module tb_rr_arb_real;

    logic              clk = 1'b0;
    logic              rst;
    logic [3:0]        req;
    logic signed [15:0] in0, in1, in2, in3;
    logic [3:0]        gnt;
    logic signed [15:0] out;
    logic              out_valid;
    logic              out_ready;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        string              name;
        logic [3:0]         req;
        logic               rdy;
        logic signed [15:0] in2;
        logic [3:0]         egnt;
        int                 eout;
        logic               evalid;
    } vec_t;

    vec_t vecs [$];

    rr_arb_real dut (
        .clk      (clk),
        .rst      (rst),
        .req      (req),
        .in0      (in0),
        .in1      (in1),
        .in2      (in2),
        .in3      (in3),
        .gnt      (gnt),
        .out      (out),
        .out_valid(out_valid),
        .out_ready(out_ready)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic vec_t mk(input string name, input logic [3:0] r, input logic rdy,
                                input logic signed [15:0] i2, input logic [3:0] eg,
                                input int eo, input logic ev);
        vec_t v;
        v.name = name; v.req = r; v.rdy = rdy; v.in2 = i2;
        v.egnt = eg; v.eout = eo; v.evalid = ev;
        return v;
    endfunction

    initial begin
        // in formats exponent -8, out exponent -6: values shift right by 2
        // in0=400->100, in1=-800->-200, in2=1024->256, in3=4->1
        vecs.push_back(mk("rot0", 4'b1111, 1'b1, 16'sd1024, 4'b0001,  100, 1'b1));
        vecs.push_back(mk("rot1", 4'b1111, 1'b1, 16'sd1024, 4'b0010, -200, 1'b1));
        vecs.push_back(mk("rot2", 4'b1111, 1'b1, 16'sd1024, 4'b0100,  256, 1'b1));
        vecs.push_back(mk("rot3", 4'b1111, 1'b1, 16'sd1024, 4'b1000,    1, 1'b1));
        vecs.push_back(mk("rot4", 4'b1111, 1'b1, 16'sd1024, 4'b0001,  100, 1'b1));
        vecs.push_back(mk("rot5", 4'b1111, 1'b1, 16'sd1024, 4'b0010, -200, 1'b1));
        vecs.push_back(mk("rot6", 4'b1111, 1'b1, 16'sd1024, 4'b0100,  256, 1'b1));
        vecs.push_back(mk("rot7", 4'b1111, 1'b1, 16'sd1024, 4'b1000,    1, 1'b1));
        vecs.push_back(mk("align_pos", 4'b0100, 1'b1, 16'sd384,  4'b0100,  96, 1'b1));
        vecs.push_back(mk("align_neg", 4'b0100, 1'b1, -16'sd385, 4'b0100, -97, 1'b1));
        for (int i = 0; i < 5; i++)
            vecs.push_back(mk("bp_hold", 4'b0110, 1'b0, -16'sd385, 4'b0000, -97, 1'b1));
        vecs.push_back(mk("bp_release", 4'b0110, 1'b1, -16'sd385, 4'b0010, -200, 1'b1));
        vecs.push_back(mk("drain0", 4'b0000, 1'b1, -16'sd385, 4'b0000, -200, 1'b0));
        vecs.push_back(mk("drain1", 4'b0000, 1'b1, -16'sd385, 4'b0000, -200, 1'b0));
        vecs.push_back(mk("pre_rst", 4'b0010, 1'b1, -16'sd385, 4'b0010, -200, 1'b1));

        in0 = 16'sd400; in1 = -16'sd800; in2 = 16'sd1024; in3 = 16'sd4;
        rst = 1'b1; req = 4'b1111; out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_out",   int'(out), 0);
        chk("reset_valid", int'(out_valid), 0);
        chk("reset_gnt",   int'(gnt), 0);
        rst = 1'b0;

        foreach (vecs[i]) begin
            req = vecs[i].req; out_ready = vecs[i].rdy; in2 = vecs[i].in2;
            #1;
            chk({vecs[i].name, "_gnt"}, int'(gnt), int'(vecs[i].egnt));
            @(posedge clk);
            #1;
            chk({vecs[i].name, "_out"},   int'(out), vecs[i].eout);
            chk({vecs[i].name, "_valid"}, int'(out_valid), int'(vecs[i].evalid));
        end

        // out_valid=1 and last=1 here; reset between edges must clear immediately
        req = 4'b0000; out_ready = 1'b0;
        #2 rst = 1'b1;
        #1;
        chk("midrst_out",   int'(out), 0);
        chk("midrst_valid", int'(out_valid), 0);
        chk("midrst_gnt",   int'(gnt), 0);
        #1 rst = 1'b0;
        req = 4'b1010; out_ready = 1'b1;
        #1;
        chk("postrst_gnt", int'(gnt), 4'b0010);
        @(posedge clk);
        #1;
        chk("postrst_out",   int'(out), -200);
        chk("postrst_valid", int'(out_valid), 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
